clk_tick_sched: RTL
===================

# clk_tick_sched

Multi-channel programmable tick scheduler that sits beside the system clock divider and shares one sys_clk domain among NCH independent periodic-strobe requesters. Each channel is configured through a valid/ready port with a period and enable. It then produces a single-cycle tick strobe and a divided square-wave clock-enable (clk_out) for that channel. Reconfiguration of a running channel is deferred to its next tick boundary so downstream logic never sees a truncated period.

## Interface
- NCH, 4: number of channels (2..8)
- DW, 16: period field width
- CW, 2: channel index width, clog2(NCH)

- sys_clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready at a sys_clk edge
- cfg_ch  in  CW  target channel
- cfg_div  in  DW  tick period in sys_clk cycles; 0 treated as 1
- cfg_en  in  1  channel enable
- sync_start  in  1  one-cycle pulse; realigns all enabled channels
- tick  out  NCH  registered one-cycle strobe per channel
- clk_out  out  NCH  registered square wave per channel, toggles on each tick
- active  out  NCH  registered enable state per channel
- pending  out  NCH  registered: a deferred config is waiting on that channel

## Operation
- Per-channel state: en, period P (DW bits, ≥1), down-counter cnt (DW bits), pending flag, and shadow registers (P, en).
- cfg_ready = !pending[cfg_ch]. This is combinational from cfg_ch and the registered pending. cfg_ch ≥ NCH gives cfg_ready = 1. The request is accepted and ignored.
- Accept to a channel with en=0:
  - Applied at the accept edge: en<=cfg_en, P<=max(cfg_div,1), cnt<=P-1, clk_out<=0, tick<=0.
- Accept to a channel with en=1:
  - The shadow registers are loaded and pending<=1. The live schedule is unchanged.
- Per-edge update for an enabled channel with no sync:
  - If cnt==0: tick<=1, clk_out<=~clk_out.
    - If pending: apply the shadow (P, en), cnt<=newP-1, pending<=0. If the new en=0, force clk_out<=0. The final tick still fires.
    - Else: cnt<=P-1.
  - Else: tick<=0, cnt<=cnt-1.
- Disabled channel: tick=0, clk_out=0, cnt held.
- sync_start at an edge:
  - Every channel with pending applies its shadow immediately.
  - Every channel enabled after that gets cnt<=P-1, clk_out<=0, tick<=0.
  - sync_start has priority over tick generation at that edge.
- Simultaneous accept and sync_start on the same edge:
  - The accepted config is applied immediately and aligned, as for a disabled channel.
- Simultaneous accept and that channel's cnt==0 edge:
  - The tick fires on the old schedule, and the config goes to shadow/pending.
  - It is applied at the following tick.
- Arithmetic:
  - cnt decrements modulo nothing. It never underflows because a reload occurs at 0.
  - The maximum period is 2^DW-1 cycles.

## Timing
- Reset values (asynchronous): tick=0, clk_out=0, active=0, pending=0, all P=1, cnt=0, shadows=0. cfg_ready=1.
- Accept at edge k on an idle channel: first tick is high in the cycle after edge k+P. Subsequent ticks follow every P cycles.
- P=1: tick is constantly high and clk_out toggles every cycle (sys_clk/2).
- The clk_out period is 2P cycles with 50% duty.
- A deferred config takes effect at the first tick edge after acceptance. The new period is measured from that edge.
- Reset asserted mid-operation clears everything, including pending configs. There are no partial ticks after deassertion.
- Outputs have no combinational path from inputs, except cfg_ready from cfg_ch.

## Test plan
- Reset, then accept ch0 div=4 en=1 at edge 10:
  - tick[0] high after edges 14, 18, 22.
  - clk_out[0] rises at 14 and falls at 18.
  - active[0]=1.
- ch1 div=0 en=1:
  - tick[1] high every cycle.
  - clk_out[1] toggles every cycle.
- ch2 running div=8:
  - Request div=3 mid-period. pending[2]=1 and cfg_ready is low for cfg_ch=2.
  - The next tick stays on the 8-grid, then ticks follow every 3 cycles, and pending clears on that tick edge.
- ch3 running div=5:
  - Request en=0. One final tick fires on schedule.
  - clk_out[3] goes to 0 and active[3] goes to 0.
  - No further ticks occur.
- Channels div=3 and div=7 running:
  - Pulse sync_start. Both clk_out go to 0.
  - Both first ticks occur 3 and 7 cycles after the sync edge.
  - A pending config is applied at the sync edge.
- Assert reset while ch0 is pending and running:
  - All outputs return to 0 asynchronously and pending is lost.
  - After release there are no ticks until reconfiguration.

Source files
------------

// File: rtl/clk_tick_sched.sv
// rtl/clk_tick_sched.sv - multi-channel programmable tick scheduler
//
// Generates, per channel, a one-cycle tick strobe every P sys_clk cycles and a
// square-wave clock enable that toggles on each tick. Reconfiguring a running
// channel is held in a shadow until its next tick, so no period is truncated.
//
// Ports:
//   sys_clk     system clock, rising edge
//   reset       asynchronous, active-low
//   cfg_valid   configuration request
//   cfg_ready   request accepted when cfg_valid && cfg_ready at an edge
//   cfg_ch      target channel
//   cfg_div     tick period in cycles (0 behaves as 1)
//   cfg_en      channel enable
//   sync_start  one-cycle pulse realigning all enabled channels
//   tick        per-channel one-cycle strobe
//   clk_out     per-channel square wave, toggles on each tick
//   active      per-channel enable state
//   pending     per-channel deferred configuration waiting
module clk_tick_sched #(
    parameter int NCH = 4,
    parameter int DW  = 16,
    parameter int CW  = 2
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [DW-1:0]     cfg_div,
    input  logic              cfg_en,
    input  logic              sync_start,
    output logic [NCH-1:0]    tick,
    output logic [NCH-1:0]    clk_out,
    output logic [NCH-1:0]    active,
    output logic [NCH-1:0]    pending
);

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [NCH-1:0] en_q, en_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] shen_q, shen_d;
    logic [NCH-1:0] tick_q, tick_d;
    logic [NCH-1:0] clko_q, clko_d;
    logic [DW-1:0]  per_q [NCH];
    logic [DW-1:0]  per_d [NCH];
    logic [DW-1:0]  cnt_q [NCH];
    logic [DW-1:0]  cnt_d [NCH];
    logic [DW-1:0]  shp_q [NCH];
    logic [DW-1:0]  shp_d [NCH];

    logic           sel_pend;
    logic [NCH-1:0] acc;
    logic [DW-1:0]  div_eff;

    // Out-of-range channel numbers match nothing, so they read as ready and
    // the accepted request is dropped.
    always_comb begin
        sel_pend = 1'b0;
        acc      = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(cfg_ch) == i) begin
                sel_pend = pend_q[i];
                acc[i]   = cfg_valid && !pend_q[i];
            end
        end
    end

    assign cfg_ready = ~sel_pend;
    assign div_eff   = (cfg_div == '0) ? ONE : cfg_div;

    always_comb begin
        en_d   = en_q;
        pend_d = pend_q;
        shen_d = shen_q;
        tick_d = '0;
        clko_d = clko_q;
        per_d  = per_q;
        cnt_d  = cnt_q;
        shp_d  = shp_q;
        for (int i = 0; i < NCH; i++) begin
            if (sync_start) begin
                // A same-edge accept wins over a shadow; the two cannot
                // coexist because a pending channel is not ready.
                if (acc[i]) begin
                    en_d[i]  = cfg_en;
                    per_d[i] = div_eff;
                end else if (pend_q[i]) begin
                    en_d[i]   = shen_q[i];
                    per_d[i]  = shp_q[i];
                    pend_d[i] = 1'b0;
                end
                if (en_d[i]) begin
                    cnt_d[i] = per_d[i] - ONE;
                end
                clko_d[i] = 1'b0;
            end else if (!en_q[i]) begin
                clko_d[i] = 1'b0;
                if (acc[i]) begin
                    en_d[i]  = cfg_en;
                    per_d[i] = div_eff;
                    cnt_d[i] = div_eff - ONE;
                end
            end else begin
                if (cnt_q[i] == '0) begin
                    tick_d[i] = 1'b1;
                    clko_d[i] = ~clko_q[i];
                    if (pend_q[i]) begin
                        en_d[i]   = shen_q[i];
                        per_d[i]  = shp_q[i];
                        cnt_d[i]  = shp_q[i] - ONE;
                        pend_d[i] = 1'b0;
                        if (!shen_q[i]) begin
                            clko_d[i] = 1'b0;
                        end
                    end else begin
                        cnt_d[i] = per_q[i] - ONE;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] - ONE;
                end
                // Checked after the tick logic: a request landing on the
                // tick edge is deferred to the following tick.
                if (acc[i]) begin
                    shp_d[i]  = div_eff;
                    shen_d[i] = cfg_en;
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            en_q   <= '0;
            pend_q <= '0;
            shen_q <= '0;
            tick_q <= '0;
            clko_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                per_q[i] <= ONE;
                cnt_q[i] <= '0;
                shp_q[i] <= '0;
            end
        end else begin
            en_q   <= en_d;
            pend_q <= pend_d;
            shen_q <= shen_d;
            tick_q <= tick_d;
            clko_q <= clko_d;
            per_q  <= per_d;
            cnt_q  <= cnt_d;
            shp_q  <= shp_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clko_q;
    assign active  = en_q;
    assign pending = pend_q;

endmodule
